// File: rtl/switch_pkg.sv
// Shared types and constants for the 4-port switch and its traffic sources.
package switch_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DATA_W    = 8;
   localparam int LEN_W     = 4;

   // Header beat layout: destination port, two reserved zero bits, payload length.
   typedef struct packed {
      logic [1:0] dest;
      logic [1:0] rsvd;
      logic [3:0] len;
   } hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY,
      ST_GAP
   } tx_state_e;

   // Builds the header beat with the reserved field forced to zero.
   function automatic hdr_t make_hdr(input logic [1:0] dest, input logic [3:0] len);
      hdr_t h;
      h.dest = dest;
      h.rsvd = 2'b00;
      h.len  = len;
      return h;
   endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock payload FIFO, first-word-fall-through: the head entry is
// visible on rd_data_o without a read strobe, and rd_next_o shows the entry
// behind it so the transmitter can register the following byte while popping.
module tx_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CNT_W = AW + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [DATA_W-1:0] rd_next_o,
   output logic              full_o,
   output logic [CNT_W-1:0]  count_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              push;
   logic              pop;

   // A write while full is dropped even if a pop frees a slot this cycle.
   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign push      = push_i && !full_o;
   assign pop       = pop_i && (count_q != '0);
   assign count_o   = count_q;
   assign rd_data_o = mem[rd_ptr_q];
   assign rd_next_o = mem[rd_ptr_q + AW'(1)];

   // Storage array is written only, never cleared.
   // NOTE: data storage has no reset; the pointers and count alone define
   // which entries are valid, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/downstream_port_tx.sv
// Packet transmitter feeding one switch input port. The host fills the
// payload FIFO, then posts a descriptor; the block emits a header beat
// followed by the payload bytes on a valid/ready link, then idles for
// GAP_CYCLES before accepting the next descriptor.
module downstream_port_tx
   import switch_pkg::*;
#(
   parameter int DATA_W     = switch_pkg::DATA_W,
   parameter int FIFO_DEPTH = 16,
   parameter int LEN_W      = switch_pkg::LEN_W,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_full,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [1:0]        desc_dest,
   input  logic [LEN_W-1:0]  desc_len,
   output logic              ds_valid,
   input  logic              ds_ready,
   output logic              ds_sop,
   output logic              ds_eop,
   output logic [DATA_W-1:0] ds_data,
   output logic [15:0]       pkt_count,
   output logic              busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   // Where the FSM goes after the EOP handshake.
   localparam tx_state_e END_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

   tx_state_e         state_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [GAP_W-1:0]  gap_q;
   logic [15:0]       pkt_count_q;
   logic              armed_q;
   logic              ds_valid_q;
   logic              ds_sop_q;
   logic              ds_eop_q;
   logic [DATA_W-1:0] ds_data_q;

   logic [DATA_W-1:0] fifo_head;
   logic [DATA_W-1:0] fifo_next;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_pop;
   logic              desc_accept;
   logic              beat_done;

   tx_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (wr_en),
      .wr_data_i (wr_data),
      .pop_i     (fifo_pop),
      .rd_data_o (fifo_head),
      .rd_next_o (fifo_next),
      .full_o    (wr_full),
      .count_o   (fifo_count)
   );

   // A descriptor is only taken once its whole payload is already buffered,
   // so the payload phase can never underrun. armed_q keeps desc_ready low
   // through reset and the first edge after it.
   assign desc_ready  = armed_q && (state_q == ST_IDLE) &&
                        (fifo_count >= CNT_W'(desc_len));
   assign desc_accept = desc_valid && desc_ready;
   assign beat_done   = ds_valid_q && ds_ready;
   assign fifo_pop    = (state_q == ST_PAY) && beat_done;

   assign ds_valid  = ds_valid_q;
   assign ds_sop    = ds_sop_q;
   assign ds_eop    = ds_eop_q;
   assign ds_data   = ds_data_q;
   assign pkt_count = pkt_count_q;
   assign busy      = (state_q != ST_IDLE);

   // Packet FSM with registered link outputs. Each beat's successor is
   // loaded on the handshake edge, so stalled beats hold and unstalled
   // payload streams at one byte per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         remaining_q <= '0;
         gap_q       <= '0;
         pkt_count_q <= '0;
         armed_q     <= 1'b0;
         ds_valid_q  <= 1'b0;
         ds_sop_q    <= 1'b0;
         ds_eop_q    <= 1'b0;
         ds_data_q   <= '0;
      end else begin
         armed_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (desc_accept) begin
                  state_q    <= ST_HDR;
                  len_q      <= desc_len;
                  ds_valid_q <= 1'b1;
                  ds_sop_q   <= 1'b1;
                  ds_eop_q   <= (desc_len == '0);
                  ds_data_q  <= DATA_W'(make_hdr(desc_dest, desc_len));
               end
            end

            ST_HDR: begin
               if (beat_done) begin
                  ds_sop_q <= 1'b0;
                  if (len_q == '0) begin
                     // Header-only packet: the header was also the EOP beat.
                     state_q     <= END_STATE;
                     gap_q       <= GAP_W'(GAP_LOAD);
                     ds_valid_q  <= 1'b0;
                     ds_eop_q    <= 1'b0;
                     pkt_count_q <= pkt_count_q + 16'd1;
                  end else begin
                     state_q     <= ST_PAY;
                     remaining_q <= len_q;
                     ds_eop_q    <= (len_q == LEN_W'(1));
                     ds_data_q   <= fifo_head;
                  end
               end
            end

            ST_PAY: begin
               if (beat_done) begin
                  if (remaining_q == LEN_W'(1)) begin
                     state_q     <= END_STATE;
                     gap_q       <= GAP_W'(GAP_LOAD);
                     ds_valid_q  <= 1'b0;
                     ds_eop_q    <= 1'b0;
                     pkt_count_q <= pkt_count_q + 16'd1;
                  end else begin
                     // The head is popped on this edge, so the byte behind
                     // it becomes the next beat.
                     remaining_q <= remaining_q - LEN_W'(1);
                     ds_eop_q    <= (remaining_q == LEN_W'(2));
                     ds_data_q   <= fifo_next;
                  end
               end
            end

            ST_GAP: begin
               if (gap_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q - GAP_W'(1);
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_downstream_port_tx.sv
// Directed bench for downstream_port_tx: a scoreboard queue receives the
// expected header and payload beats when a descriptor is accepted, and a
// negedge monitor pops and compares them as the link handshakes.
module tb_downstream_port_tx;

   localparam int DATA_W     = 8;
   localparam int LEN_W      = 4;
   localparam int DEPTH      = 16;
   localparam int GAP_CYCLES = 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_full;
   logic              desc_valid;
   logic              desc_ready;
   logic [1:0]        desc_dest;
   logic [LEN_W-1:0]  desc_len;
   logic              ds_valid;
   logic              ds_ready;
   logic              ds_sop;
   logic              ds_eop;
   logic [DATA_W-1:0] ds_data;
   logic [15:0]       pkt_count;
   logic              busy;

   typedef struct packed {
      logic       sop;
      logic       eop;
      logic [7:0] data;
   } beat_t;

   beat_t       exp_q[$];
   logic [7:0]  pay_q[$];
   int          level = 0;
   logic [15:0] exp_pkt = '0;
   int          n_total = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   bit          in_pkt = 1'b0;
   beat_t       mon_beat;

   always #5 clk = ~clk;

   downstream_port_tx #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (DEPTH),
      .LEN_W      (LEN_W),
      .GAP_CYCLES (GAP_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_full    (wr_full),
      .desc_valid (desc_valid),
      .desc_ready (desc_ready),
      .desc_dest  (desc_dest),
      .desc_len   (desc_len),
      .ds_valid   (ds_valid),
      .ds_ready   (ds_ready),
      .ds_sop     (ds_sop),
      .ds_eop     (ds_eop),
      .ds_data    (ds_data),
      .pkt_count  (pkt_count),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Link monitor: every handshake must match the oldest expected beat, and
   // once a packet has started no bubble may appear while ds_ready is high.
   always @(negedge clk) begin
      if (!reset) begin
         in_pkt = 1'b0;
      end else begin
         if (in_pkt && ds_ready) begin
            check("no_bubble", 32'(ds_valid), 32'(1'b1));
         end
         if (ds_valid && ds_ready) begin
            if (exp_q.size() == 0) begin
               check("beat_unexpected", 32'(exp_q.size()), 32'(1));
            end else begin
               mon_beat = exp_q.pop_front();
               check("beat", 32'({ds_sop, ds_eop, ds_data}), 32'(mon_beat));
               if (!mon_beat.sop) level--;
               if (mon_beat.eop) exp_pkt++;
            end
            in_pkt = !ds_eop;
         end
      end
   end

   task automatic write_byte(input logic [7:0] b);
      wr_data = b;
      wr_en   = 1'b1;
      if (level < DEPTH) begin
         pay_q.push_back(b);
         level++;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic offer_desc(input logic [1:0] dest, input logic [3:0] len);
      desc_dest  = dest;
      desc_len   = len;
      desc_valid = 1'b1;
   endtask

   // Waits for the descriptor handshake, queues the expected packet, then
   // checks the header appears on the very next cycle. Ends on a negedge.
   task automatic wait_accept();
      bit    ok = 1'b0;
      beat_t b;
      int    n;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (desc_ready) begin
            ok = 1'b1;
            n = int'(desc_len);
            b.sop  = 1'b1;
            b.eop  = (n == 0);
            b.data = {desc_dest, 2'b00, desc_len};
            exp_q.push_back(b);
            for (int k = 0; k < n; k++) begin
               b.sop  = 1'b0;
               b.eop  = (k == n - 1);
               b.data = pay_q.pop_front();
               exp_q.push_back(b);
            end
         end
         @(posedge clk); #1;
      end
      desc_valid = 1'b0;
      check("desc_accept", 32'(ok), 32'(1'b1));
      if (ok) begin
         @(negedge clk);
         check("hdr_latency", 32'({ds_valid, ds_sop}), 32'(2'b11));
         check("busy_holdoff", 32'({busy, desc_ready}), 32'(2'b10));
      end
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk); #1;
         done = (exp_q.size() == 0) && !busy;
      end
      check("drain", 32'(done), 32'(1'b1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b0;
      wr_en      = 1'b0;
      wr_data    = '0;
      desc_valid = 1'b0;
      desc_dest  = '0;
      desc_len   = '0;
      ds_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_link", 32'({ds_valid, ds_sop, ds_eop, ds_data}), 32'(0));
      check("rst_ctrl", 32'({wr_full, desc_ready, busy}), 32'(0));
      check("rst_pkt", 32'(pkt_count), 32'(0));
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end

      // Basic packet: dest 2, three bytes, streamed back to back.
      ds_ready = 1'b1;
      write_byte(8'hA1);
      write_byte(8'hA2);
      write_byte(8'hA3);
      offer_desc(2'd2, 4'd3);
      wait_accept();
      wait_drain();
      check("pkt_count_1", 32'(pkt_count), 32'(16'd1));

      // Header-only packet followed by exactly one idle gap cycle.
      offer_desc(2'd1, 4'd0);
      wait_accept();
      @(posedge clk); #1;
      check("gap_idle", 32'({ds_valid, busy}), 32'(2'b01));
      @(posedge clk); #1;
      check("gap_done", 32'({ds_valid, busy}), 32'(2'b00));
      check("pkt_count_hdr", 32'(pkt_count), 32'(exp_pkt));

      // Descriptor held off until its whole payload is buffered.
      write_byte(8'hC1);
      write_byte(8'hC2);
      offer_desc(2'd0, 4'd5);
      repeat (3) begin
         @(negedge clk);
         check("underrun_hold", 32'(desc_ready), 32'(1'b0));
         @(posedge clk); #1;
      end
      write_byte(8'hC3);
      check("underrun_hold3", 32'(desc_ready), 32'(1'b0));
      write_byte(8'hC4);
      check("underrun_hold4", 32'(desc_ready), 32'(1'b0));
      write_byte(8'hC5);
      wait_accept();
      wait_drain();

      // Receiver stalls two cycles mid-payload: beat must hold.
      write_byte(8'hD1);
      write_byte(8'hD2);
      write_byte(8'hD3);
      write_byte(8'hD4);
      offer_desc(2'd3, 4'd4);
      wait_accept();
      @(posedge clk); #1;
      @(posedge clk); #1;
      ds_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("stall_hold", 32'({ds_valid, ds_sop, ds_eop, ds_data}),
               32'({1'b1, 1'b0, 1'b0, exp_q[0].data}));
         @(posedge clk); #1;
      end
      ds_ready = 1'b1;
      wait_drain();

      // Overfill: 16 bytes fit, the 17th is dropped.
      for (int i = 0; i < 17; i++) begin
         write_byte(8'h10 + 8'(i));
         if (i == 14) check("not_full_15", 32'(wr_full), 32'(1'b0));
         if (i >= 15) check("full", 32'(wr_full), 32'(1'b1));
      end
      offer_desc(2'd3, 4'd15);
      wait_accept();
      wait_drain();
      offer_desc(2'd0, 4'd1);
      wait_accept();
      wait_drain();
      check("pkt_count_6", 32'(pkt_count), 32'(exp_pkt));

      // Reset in the middle of a payload truncates and flushes everything.
      write_byte(8'hE1);
      write_byte(8'hE2);
      write_byte(8'hE3);
      write_byte(8'hE4);
      offer_desc(2'd2, 4'd4);
      wait_accept();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("midrst_link", 32'({ds_valid, ds_sop, ds_eop}), 32'(0));
      check("midrst_ctrl", 32'({busy, wr_full, desc_ready}), 32'(0));
      check("midrst_pkt", 32'(pkt_count), 32'(0));
      exp_q.delete();
      pay_q.delete();
      level   = 0;
      exp_pkt = '0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      offer_desc(2'd0, 4'd1);
      @(negedge clk);
      check("fifo_flushed", 32'(desc_ready), 32'(1'b0));
      @(posedge clk); #1;
      desc_valid = 1'b0;
      write_byte(8'hF1);
      write_byte(8'hF2);
      offer_desc(2'd1, 4'd2);
      wait_accept();
      wait_drain();
      check("pkt_after_rst", 32'(pkt_count), 32'(16'd1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
